// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator with pixel-rate divider,
// scan counters, registered active-low syncs and pixel/frame strobes.
`default_nettype none

module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       f_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             line_end;
  logic             frame_end;

  assign p_tick    = (div_cnt == DIV_LAST);
  // Wrap on >= so a count can never run past the last position.
  assign line_end  = (pixel_x >= H_LAST);
  assign frame_end = (pixel_y >= V_LAST);

  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (p_tick) begin
      if (line_end) begin
        x_next = 10'd0;
        y_next = frame_end ? 10'd0 : pixel_y + 10'd1;
      end else begin
        x_next = pixel_x + 10'd1;
      end
    end
  end

  // Syncs come from the next-state counts so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pixel_x <= 10'd0;
      pixel_y <= 10'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + 1'b1;
      pixel_x <= x_next;
      pixel_y <= y_next;
      hsync   <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
      vsync   <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    end
  end

  assign video_on = (pixel_x < H_VIS) && (pixel_y < V_VIS);
  assign f_tick   = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen using a scaled-down raster
// (25 x 11 positions, divide-by-4) so whole frames fit in a short run.
`default_nettype none

module tb_vga_sync_gen;

  // Scaled raster: H = 16+2+4+3 = 25, V = 6+1+2+2 = 11, 275 pixels/frame.
  localparam int HT       = 25;
  localparam int VT       = 11;
  localparam int FRAME    = HT * VT;
  localparam int HS_LO    = 18;
  localparam int HS_HI    = 21;
  localparam int VS_LO    = 7;
  localparam int VS_HI    = 8;
  localparam int H_VIS    = 16;
  localparam int V_VIS    = 6;
  localparam int DIV      = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync, vsync, video_on, p_tick, f_tick;
  logic [9:0] pixel_x, pixel_y;

  vga_sync_gen #(
    .CLK_DIV(DIV), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .f_tick(f_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ft;
  } exp_t;

  exp_t        q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  bit          mon_en     = 1'b0;
  bit          meas_en    = 1'b0;
  bit          edge_rst   = 1'b1;
  bit          edge_pt    = 1'b0;
  int          cyc        = 0;
  int          ft_times[$];
  int          hs_times[$];
  bit          have_prev  = 1'b0;
  logic [22:0] prev_hold  = '0;
  logic        prev_hs    = 1'b1;
  logic        prev_pt    = 1'b0;

  localparam logic [24:0] RST_STATE = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Expected outputs at scan position k counted from the first p_tick after reset.
  function automatic exp_t model(input int k);
    exp_t m;
    int x, y;
    x     = k % HT;
    y     = (k / HT) % VT;
    m.x   = 10'(x);
    m.y   = 10'(y);
    m.hs  = !(x >= HS_LO && x <= HS_HI);
    m.vs  = !(y >= VS_LO && y <= VS_HI);
    m.von = (x < H_VIS) && (y < V_VIS);
    m.ft  = (x == HT - 1) && (y == VT - 1);
    return m;
  endfunction

  task automatic push_seq(input int n);
    for (int k = 0; k < n; k++) q.push_back(model(k));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < DIV * 1000 + 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      bound_fail(name);
      q.delete();
    end
    mon_en = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    edge_rst = reset;
    edge_pt  = p_tick;
    cyc++;
  end

  // Monitor: pops one expectation per p_tick; also checks strobe shape and hold.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      if (p_tick) begin
        if (q.size() == 0) begin
          bound_fail("scoreboard_underrun");
        end else begin
          e = q.pop_front();
          chk("scan", 32'({pixel_x, pixel_y, hsync, vsync, video_on, f_tick}), 32'(e));
        end
      end
      chk("ptick_pair", 32'(p_tick & prev_pt), 32'd0);
      chk("ftick_alone", 32'(f_tick & ~p_tick), 32'd0);
      if (have_prev && !edge_rst && !edge_pt)
        chk("hold", 32'({pixel_x, pixel_y, hsync, vsync, video_on}), 32'(prev_hold));
    end
    if (meas_en) begin
      if (f_tick) ft_times.push_back(cyc);
      if (prev_hs && !hsync) hs_times.push_back(cyc);
    end
    prev_hold = {pixel_x, pixel_y, hsync, vsync, video_on};
    prev_hs   = hsync;
    prev_pt   = p_tick;
    have_prev = mon_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("reset_state", 32'({pixel_x, pixel_y, hsync, vsync, video_on, p_tick, f_tick}), 32'(RST_STATE));
    end

    // Release and run three full frames plus one pixel.
    push_seq(3 * FRAME + 1);
    reset   = 1'b0;
    mon_en  = 1'b1;
    meas_en = 1'b1;
    chk("ptick_rel_c1", 32'(p_tick), 32'd0);
    @(negedge clk); chk("ptick_rel_c2", 32'(p_tick), 32'd0);
    @(negedge clk); chk("ptick_rel_c3", 32'(p_tick), 32'd0);
    @(negedge clk); chk("first_ptick", 32'({p_tick, pixel_x}), 32'({1'b1, 10'd0}));
    @(negedge clk); chk("x_after_first", 32'(pixel_x), 32'd1);
    drain("three_frames");
    meas_en = 1'b0;

    chk("ftick_count", 32'(ft_times.size()), 32'd3);
    for (int i = 1; i < ft_times.size(); i++)
      chk("ftick_spacing", 32'(ft_times[i] - ft_times[i-1]), 32'(FRAME * DIV));
    chk("hsync_fall_count", 32'(hs_times.size()), 32'd33);
    for (int i = 1; i < hs_times.size(); i++)
      chk("hsync_period", 32'(hs_times[i] - hs_times[i-1]), 32'(HT * DIV));

    // Mid-frame reset with both syncs asserted, off a p_tick.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pixel_x == 10'd20 && pixel_y == 10'd8) && n < 3000);
    if (!(pixel_x == 10'd20 && pixel_y == 10'd8)) bound_fail("reach_x20_y8");
    chk("syncs_low_before_reset", 32'({hsync, vsync, video_on}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midframe_reset", 32'({pixel_x, pixel_y, hsync, vsync, video_on, p_tick, f_tick}), 32'(RST_STATE));
    q.delete();
    push_seq(31);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk); chk("restart_c2", 32'(p_tick), 32'd0);
    @(negedge clk); chk("restart_c3", 32'(p_tick), 32'd0);
    @(negedge clk); chk("restart_ptick", 32'({p_tick, pixel_x, pixel_y}), 32'({1'b1, 10'd0, 10'd0}));
    drain("after_midframe_reset");

    // Reset on the p_tick of the last visible pixel: counts must not advance.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p_tick && pixel_x == 10'd15) && n < 3000);
    if (!(p_tick && pixel_x == 10'd15)) bound_fail("reach_ptick_x15");
    reset = 1'b1;
    @(negedge clk);
    chk("reset_on_ptick", 32'({pixel_x, pixel_y, hsync, vsync, video_on, p_tick, f_tick}), 32'(RST_STATE));
    q.delete();
    push_seq(6);
    reset  = 1'b0;
    mon_en = 1'b1;
    drain("after_ptick_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
